if_id_buf: RTL

Parametrised IF/ID pipeline stage buffer, the next generation of the plain IF/ID latch. It sits between instruction fetch and decode and carries the fetch PC and instruction word under a valid/ready handshake. It adds stall and flush control and an optional second (skid) entry, so fetch never needs a combinational path from decode's ready. With stall, flush and the skid disabled, and both sides always valid/ready, it degenerates to the original one-cycle register.

---
 rtl/if_id_buf.sv | 96 +++++++++
 1 files changed

// File: rtl/if_id_buf.sv
// IF/ID stage buffer: carries fetch PC/instruction to decode under valid/ready,
// with stall, flush and an optional skid entry that keeps if_ready registered.
module if_id_buf #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic [INST_W-1:0] if_inst,
  input  logic              stall,
  input  logic              flush,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic [1:0]        occ
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} occ_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  occ_e   state_q;
  entry_t head_q, skid_q, in_e;
  logic   rdy_en_q;
  logic   accept, pop;

  assign in_e     = '{pc: if_pc, inst: if_inst};
  assign id_valid = (state_q != EMPTY);
  assign pop      = id_valid & id_ready & ~stall;
  assign accept   = if_valid & if_ready;
  assign occ      = state_q;

  // Idle slots present zeros so decode sees a NOP bubble.
  assign id_pc   = id_valid ? head_q.pc   : '0;
  assign id_inst = id_valid ? head_q.inst : '0;

  // rdy_en_q holds if_ready low through reset and releases it one edge later.
  generate
    if (SKID != 0) begin : g_skid
      assign if_ready = rdy_en_q & (state_q != TWO);
    end else begin : g_noskid
      assign if_ready = rdy_en_q & ((state_q == EMPTY) | pop);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= EMPTY;
      head_q   <= '0;
      skid_q   <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      if (flush) begin
        state_q <= EMPTY;
        head_q  <= '0;
        skid_q  <= '0;
      end else begin
        case (state_q)
          EMPTY: begin
            if (accept) begin
              head_q  <= in_e;
              state_q <= ONE;
            end
          end
          ONE: begin
            if (accept && pop) begin
              head_q <= in_e;
            end else if (pop) begin
              state_q <= EMPTY;
            end else if (accept && (SKID != 0)) begin
              skid_q  <= in_e;
              state_q <= TWO;
            end
          end
          TWO: begin
            if (pop) begin
              head_q  <= skid_q;
              state_q <= ONE;
            end
          end
          default: state_q <= EMPTY;
        endcase
      end
    end
  end

endmodule
